// File: rtl/hilo_mac.sv
// Multi-cycle radix-2 shift-add multiply / multiply-accumulate unit that owns
// the architectural HI/LO pair (mul, madd, maddu).
module hilo_mac #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [5:0] OP_MADD  = 6'd6;
  localparam logic [5:0] OP_MADDU = 6'd7;
  localparam logic [5:0] OP_MUL   = 6'd39;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t             state_r;
  logic [5:0]         op_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] prod_r;
  logic               neg_r;
  logic [CW-1:0]      count_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               valid_op_s;
  logic               signed_op_s;
  logic [WIDTH:0]     upper_s;
  logic [WIDTH:0]     step_hi_s;
  logic [2*WIDTH-1:0] signed_prod_s;
  logic [2*WIDTH-1:0] result_s;

  // Magnitude of a two's-complement operand; the most-negative value maps to itself.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    abs_val = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Opcode decode, one shift-add step, and the final sign fix / accumulate.
  always_comb begin
    valid_op_s  = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MUL);
    signed_op_s = (op == OP_MADD) || (op == OP_MUL);
    upper_s     = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    if (mplier_r[0]) begin
      step_hi_s = upper_s + {1'b0, mcand_r};
    end else begin
      step_hi_s = upper_s;
    end
    if (neg_r) begin
      signed_prod_s = ~prod_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      signed_prod_s = prod_r;
    end
    if (op_r == OP_MUL) begin
      result_s = signed_prod_s;
    end else begin
      result_s = {hi_r, lo_r} + signed_prod_s;
    end
  end

  // Control FSM, datapath registers and the architectural HI/LO pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= 6'd0;
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      neg_r    <= 1'b0;
      count_r  <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else if (clr) begin
      // Clear wins over everything, including a start in the same cycle.
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && valid_op_s) begin
            op_r     <= op;
            mcand_r  <= signed_op_s ? abs_val(a) : a;
            mplier_r <= signed_op_s ? abs_val(b) : b;
            neg_r    <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            prod_r   <= {(2*WIDTH){1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          prod_r   <= {step_hi_s, prod_r[WIDTH-1:1]};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CW'(WIDTH - 1)) begin
            state_r <= ACC;
          end else begin
            state_r <= CALC;
          end
        end
        ACC: begin
          {hi_r, lo_r} <= result_s;
          busy_r       <= 1'b0;
          done_r       <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_mac.sv
// Self-checking bench for hilo_mac: vector table plus scoreboard queue, and
// hand sequences for invalid op, start-while-busy, reset and clear corner cases.
module tb_hilo_mac;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, clr;
  logic [5:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] cur_acc = 64'd0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[10];

  hilo_mac #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .clr(clr), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_step(input logic [5:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
    logic [63:0] p;
    if (o == 6'd7) p = {32'd0, x} * {32'd0, y};
    else           p = longint'($signed(x)) * longint'($signed(y));
    return (o == 6'd39) ? p : acc + p;
  endfunction

  // Called just after a negedge; the start is accepted on the next posedge.
  task automatic do_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input string name);
    int cycles, busy_cnt;
    logic stable;
    logic [63:0] got;
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; op = 6'd39; a = $urandom; b = $urandom;
    check($sformatf("%s_busy", name), {63'd0, busy}, 64'd1);
    check($sformatf("%s_done_low", name), {63'd0, done}, 64'd0);
    cycles = 1; busy_cnt = busy ? 1 : 0; stable = 1'b1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (!done && {hi, lo} !== cur_acc) stable = 1'b0;
    end
    got = sb_q.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check($sformatf("%s_latency", name), 64'(cycles), 64'(W + 2));
      check($sformatf("%s_busy_len", name), 64'(busy_cnt), 64'(W + 1));
      check($sformatf("%s_stable", name), {63'd0, stable}, 64'd1);
      check($sformatf("%s_result", name), {hi, lo}, got);
    end
    cur_acc = exp;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [5:0] ro;
    logic [31:0] rx, ry;
    logic [63:0] re;

    tbl[0] = '{6'd39, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1] = '{6'd39, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    tbl[2] = '{6'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0002};
    tbl[3] = '{6'd39, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{6'd6,  32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0000};
    tbl[5] = '{6'd39, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    tbl[6] = '{6'd6,  32'h8000_0000, 32'h0000_0001, 64'h3FFF_FFFF_8000_0000};
    tbl[7] = '{6'd7,  32'h8000_0000, 32'h0000_0002, 64'h4000_0000_8000_0000};
    tbl[8] = '{6'd39, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    tbl[9] = '{6'd6,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};

    rst_n = 1'b0; start = 1'b0; clr = 1'b0; op = 6'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each op starts in the cycle its predecessor pulses done.
    for (int i = 0; i < 10; i++) do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(2, 0))
        0: ro = 6'd6;
        1: ro = 6'd7;
        default: ro = 6'd39;
      endcase
      rx = $urandom; ry = $urandom;
      re = model_step(ro, rx, ry, cur_acc);
      do_op(ro, rx, ry, re, $sformatf("rnd%0d", i));
    end

    // Unsupported opcode is ignored.
    @(negedge clk);
    start = 1'b1; op = 6'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", {63'd0, busy}, 64'd0);
    count_dones(36, n);
    check("badop_no_done", 64'(n), 64'd0);
    check("badop_hilo", {hi, lo}, cur_acc);

    // Start pulse while busy is dropped: one done, first operation's result.
    start = 1'b1; op = 6'd39; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 6'd39; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    count_dones(45, n);
    check("busy_start_one_done", 64'(n), 64'd1);
    check("busy_start_result", {hi, lo}, 64'd15);
    cur_acc = 64'd15;

    // Asynchronous reset at cycle 10 of CALC.
    start = 1'b1; op = 6'd39; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_acc = 64'd0;
    count_dones(40, n);
    check("rst_no_done", 64'(n), 64'd0);

    // Clear in the middle of CALC aborts and zeroes HI/LO.
    do_op(6'd39, 32'd4, 32'd5, 64'd20, "pre_clr");
    start = 1'b1; op = 6'd6; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_mid_busy", {63'd0, busy}, 64'd0);
    check("clr_mid_hilo", {hi, lo}, 64'd0);
    cur_acc = 64'd0;
    count_dones(40, n);
    check("clr_mid_no_done", 64'(n), 64'd0);

    // Clear together with start: start dropped.
    do_op(6'd39, 32'd4, 32'd5, 64'd20, "pre_clr2");
    start = 1'b1; clr = 1'b1; op = 6'd39; a = 32'd6; b = 32'd6;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    check("clr_start_busy", {63'd0, busy}, 64'd0);
    check("clr_start_hilo", {hi, lo}, 64'd0);
    count_dones(40, n);
    check("clr_start_no_done", 64'(n), 64'd0);
    check("clr_start_hilo_after", {hi, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
